// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: ordered power-rail sequencer with PG timeout / PG-loss
// supervision and reverse-order shutdown.
module pwr_seq_ctrl #(
    parameter int N_RAIL     = 4,
    parameter int CLK_PER_MS = 50000,
    parameter int DLY_W      = 11,
    parameter int PG_TMO_MS  = 20,
    parameter int OFF_DLY_MS = 2,
    parameter int PG_FILT    = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      seq_en,
    input  logic                      fault_clr,
    input  logic [N_RAIL-1:0]         pg,
    input  logic [N_RAIL*DLY_W-1:0]   on_dly_ms,
    output logic [N_RAIL-1:0]         rail_en,
    output logic                      rst_n_out,
    output logic                      seq_done,
    output logic                      fault,
    output logic [2:0]                fault_rail,
    output logic                      fault_tmo,
    output logic [2:0]                state
);

    localparam int IW = (N_RAIL > 1) ? $clog2(N_RAIL) : 1;
    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MW = (DLY_W > 16) ? DLY_W : 16;
    localparam int FW = $clog2(PG_FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EN_RAIL = 3'd1,
        S_WAIT_PG = 3'd2,
        S_DLY     = 3'd3,
        S_ON      = 3'd4,
        S_PWR_DN  = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_RAIL-1:0]   pg_s1_q, pg_s2_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MW-1:0]       ms_q, ms_d;
    logic [N_RAIL-1:0]   rail_q, rail_d;
    logic [N_RAIL-1:0]   armed_q, armed_d;
    logic [FW-1:0]       flt_q [N_RAIL];
    logic [FW-1:0]       flt_d [N_RAIL];
    logic                rst_q, rst_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [2:0]          frail_q, frail_d;
    logic                ftmo_q, ftmo_d;

    logic                tick;
    logic [MW:0]         ms_nx;
    logic                pg_cur;
    logic [DLY_W-1:0]    dly_cur;
    logic                dly_done;
    logic                active;
    logic                loss;
    logic [IW-1:0]       loss_j;
    logic                do_flt;
    logic [IW-1:0]       flt_idx;
    logic                flt_tmo;
    logic                go_dn;
    logic                clr_ms;
    logic                phase_chg;

    assign tick     = (cnt_q == CW'(CLK_PER_MS - 1));
    assign ms_nx    = {1'b0, ms_q} + (MW+1)'(1);
    assign pg_cur   = pg_s2_q[idx_q];
    assign dly_cur  = on_dly_ms[int'(idx_q) * DLY_W +: DLY_W];
    assign dly_done = (dly_cur == '0)
                    || (tick && ms_nx >= (MW+1)'(dly_cur));
    assign active   = (state_q == S_EN_RAIL) || (state_q == S_WAIT_PG)
                    || (state_q == S_DLY) || (state_q == S_ON);

    // Consecutive-low filter on every rail that has already proven good
    always_comb begin
        for (int j = 0; j < N_RAIL; j++) begin
            flt_d[j] = '0;
            if (armed_q[j] && !pg_s2_q[j]) begin
                flt_d[j] = (flt_q[j] == FW'(PG_FILT)) ? flt_q[j]
                                                     : flt_q[j] + FW'(1);
            end
        end
    end

    // Scan downward so the lowest losing rail is reported
    always_comb begin
        loss   = 1'b0;
        loss_j = '0;
        for (int j = N_RAIL - 1; j >= 0; j--) begin
            if (armed_q[j] && !pg_s2_q[j]
                && flt_q[j] == FW'(PG_FILT - 1)) begin
                loss   = 1'b1;
                loss_j = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rail_d  = rail_q;
        armed_d = armed_q;
        fault_d = fault_q;
        frail_d = frail_q;
        ftmo_d  = ftmo_q;
        do_flt  = 1'b0;
        flt_idx = '0;
        flt_tmo = 1'b0;
        go_dn   = 1'b0;
        clr_ms  = 1'b0;

        if (active && loss) begin
            do_flt  = 1'b1;
            flt_idx = loss_j;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (seq_en) begin
                        state_d = S_EN_RAIL;
                        idx_d   = '0;
                        rail_d  = (rail_q << 1) | N_RAIL'(1);
                    end
                end
                S_EN_RAIL: begin
                    if (!seq_en) go_dn = 1'b1;
                    else         state_d = S_WAIT_PG;
                end
                S_WAIT_PG: begin
                    if (!pg_cur && tick
                        && ms_nx >= (MW+1)'(PG_TMO_MS)) begin
                        do_flt  = 1'b1;
                        flt_idx = idx_q;
                        flt_tmo = 1'b1;
                    end else if (!seq_en) begin
                        go_dn = 1'b1;
                    end else if (pg_cur) begin
                        state_d        = S_DLY;
                        armed_d[idx_q] = 1'b1;
                    end
                end
                S_DLY: begin
                    if (!seq_en) begin
                        go_dn = 1'b1;
                    end else if (dly_done) begin
                        if (idx_q == IW'(N_RAIL - 1)) begin
                            state_d = S_ON;
                        end else begin
                            state_d = S_EN_RAIL;
                            idx_d   = idx_q + IW'(1);
                            rail_d  = (rail_q << 1) | N_RAIL'(1);
                        end
                    end
                end
                S_ON: begin
                    if (!seq_en) go_dn = 1'b1;
                end
                S_PWR_DN: begin
                    // Thermometer code: a right shift drops the top rail
                    if (rail_q == '0) begin
                        state_d = fault_q ? S_FAULT : S_IDLE;
                    end else if (tick
                                 && ms_nx >= (MW+1)'(OFF_DLY_MS)) begin
                        rail_d = rail_q >> 1;
                        clr_ms = 1'b1;
                    end
                end
                S_FAULT: begin
                    if (fault_clr && !seq_en) begin
                        state_d = S_IDLE;
                        fault_d = 1'b0;
                        frail_d = '0;
                        ftmo_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_flt) begin
            go_dn   = 1'b1;
            fault_d = 1'b1;
            frail_d = 3'(flt_idx);
            ftmo_d  = flt_tmo;
        end
        if (go_dn) begin
            state_d = S_PWR_DN;
            rail_d  = rail_q >> 1;
            armed_d = '0;
        end

        rst_d  = (state_d == S_ON);
        done_d = (state_d == S_ON);

        // Prescaler and ms count restart whenever the phase changes
        phase_chg = (state_d != state_q) || (idx_d != idx_q);
        cnt_d = (phase_chg || tick) ? '0 : cnt_q + CW'(1);
        if (phase_chg || clr_ms) ms_d = '0;
        else if (tick)           ms_d = (&ms_q) ? ms_q : ms_q + MW'(1);
        else                     ms_d = ms_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pg_s1_q <= '0;
            pg_s2_q <= '0;
            cnt_q   <= '0;
            ms_q    <= '0;
            rail_q  <= '0;
            armed_q <= '0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            frail_q <= '0;
            ftmo_q  <= 1'b0;
            for (int j = 0; j < N_RAIL; j++) flt_q[j] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pg_s1_q <= pg;
            pg_s2_q <= pg_s1_q;
            cnt_q   <= cnt_d;
            ms_q    <= ms_d;
            rail_q  <= rail_d;
            armed_q <= armed_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            frail_q <= frail_d;
            ftmo_q  <= ftmo_d;
            for (int j = 0; j < N_RAIL; j++) flt_q[j] <= flt_d[j];
        end
    end

    assign rail_en    = rail_q;
    assign rst_n_out  = rst_q;
    assign seq_done   = done_q;
    assign fault      = fault_q;
    assign fault_rail = frail_q;
    assign fault_tmo  = ftmo_q;
    assign state      = state_q;

endmodule
